// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - instruction-fetch PC generator with single outstanding request and one-entry output buffer
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_jmp_en,
   input  logic [31:0] wb_jmp_pc,
   input  logic        br_jmp_en,
   input  logic [31:0] br_jmp_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_addr_ok,
   input  logic        imem_data_ok,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_adel
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cur_pc, cur_pc_d;
   logic [31:0] buf_pc, buf_pc_d;
   logic [31:0] buf_instr, buf_instr_d;
   logic        buf_adel, buf_adel_d;
   logic        discard, discard_d;
   logic        bubble, bubble_d;
   logic        misaligned;

   // A misaligned fetch PC never reaches memory; it becomes an AdEL entry instead.
   // The bubble flag suppresses the request for one cycle after a writeback redirect in REQ.
   assign misaligned = (pc_q[1:0] != 2'b00);
   assign imem_req   = (state == S_REQ) && !bubble && !misaligned;
   assign imem_addr  = pc_q;
   assign out_valid  = (state == S_HOLD);
   assign out_pc     = buf_pc;
   assign out_instr  = buf_instr;
   assign out_adel   = buf_adel;

   // Next-state, next-PC and buffer-load decisions; writeback redirect overrides everything.
   always_comb begin
      state_d     = state;
      pc_d        = pc_q;
      cur_pc_d    = cur_pc;
      buf_pc_d    = buf_pc;
      buf_instr_d = buf_instr;
      buf_adel_d  = buf_adel;
      discard_d   = discard;
      bubble_d    = 1'b0;
      case (state)
         S_REQ: begin
            if (wb_jmp_en) begin
               pc_d = wb_jmp_pc;
               if (imem_req && imem_addr_ok) begin
                  cur_pc_d  = pc_q;
                  discard_d = 1'b1;
                  state_d   = S_WAIT;
               end else begin
                  bubble_d = 1'b1;
               end
            end else begin
               if (!bubble) begin
                  if (misaligned) begin
                     buf_pc_d    = pc_q;
                     buf_instr_d = 32'h0;
                     buf_adel_d  = 1'b1;
                     state_d     = S_HOLD;
                  end else if (imem_addr_ok) begin
                     cur_pc_d = pc_q;
                     pc_d     = pc_q + 32'd4;
                     state_d  = S_WAIT;
                  end
               end
               if (br_jmp_en) begin
                  pc_d = br_jmp_pc;
               end
            end
         end
         S_WAIT: begin
            if (wb_jmp_en) begin
               pc_d = wb_jmp_pc;
               if (imem_data_ok) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  discard_d = 1'b1;
               end
            end else begin
               if (imem_data_ok) begin
                  if (discard) begin
                     discard_d = 1'b0;
                     state_d   = S_REQ;
                  end else begin
                     buf_pc_d    = cur_pc;
                     buf_instr_d = imem_rdata;
                     buf_adel_d  = 1'b0;
                     state_d     = S_HOLD;
                  end
               end
               if (br_jmp_en) begin
                  pc_d = br_jmp_pc;
               end
            end
         end
         S_HOLD: begin
            if (wb_jmp_en) begin
               pc_d    = wb_jmp_pc;
               state_d = S_REQ;
            end else begin
               if (out_ready) begin
                  state_d = S_REQ;
               end
               if (br_jmp_en) begin
                  pc_d = br_jmp_pc;
               end
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= S_REQ;
         pc_q      <= RESET_PC;
         cur_pc    <= 32'h0;
         buf_pc    <= 32'h0;
         buf_instr <= 32'h0;
         buf_adel  <= 1'b0;
         discard   <= 1'b0;
         bubble    <= 1'b0;
      end else begin
         state     <= state_d;
         pc_q      <= pc_d;
         cur_pc    <= cur_pc_d;
         buf_pc    <= buf_pc_d;
         buf_instr <= buf_instr_d;
         buf_adel  <= buf_adel_d;
         discard   <= discard_d;
         bubble    <= bubble_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - randomized self-checking bench for fetch_pc_gen against a fetch-stream model
module tb_fetch_pc_gen;

   localparam logic [31:0] RST_PC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wb_jmp_en, br_jmp_en;
   logic [31:0] wb_jmp_pc, br_jmp_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_addr_ok, imem_data_ok;
   logic [31:0] imem_rdata;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_instr;
   logic        out_adel;

   fetch_pc_gen #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .resetn(resetn),
      .wb_jmp_en(wb_jmp_en), .wb_jmp_pc(wb_jmp_pc),
      .br_jmp_en(br_jmp_en), .br_jmp_pc(br_jmp_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_addr_ok(imem_addr_ok), .imem_data_ok(imem_data_ok), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } ent_t;

   int checks = 0;
   int failures = 0;

   // model state: next expected fetch PC and instructions owed to decode, in order
   logic [31:0] exp_pc;
   ent_t        exp_q[$];
   // memory slave state
   bit          slave_busy;
   logic [31:0] slave_addr;
   int          slave_cnt;
   int          lat;
   // previous-cycle observations
   bit          prev_wb, prev_hold;
   logic [31:0] prev_pc, prev_instr;
   logic        prev_adel;
   // delivery bookkeeping
   int          deliveries;
   logic [31:0] last_pc, last_instr;
   logic        last_adel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h3c1d, a[31:16]} + 32'h0000_1001;
   endfunction

   function automatic void model_reset();
      exp_pc     = RST_PC;
      exp_q.delete();
      slave_busy = 0;
      slave_cnt  = 0;
      prev_wb    = 0;
      prev_hold  = 0;
   endfunction

   // One clock cycle: observe at negedge, check, drive inputs, advance the model, wait for next negedge.
   task automatic step(input bit a_ok, input bit rdy, input bit wb, input logic [31:0] wpc,
                       input bit br, input logic [31:0] bpc, input bit d_en);
      logic        req_s, ov_s, adel_s;
      logic [31:0] addr_s, pc_s, instr_s;
      bit          dok;
      ent_t        e;
      req_s = imem_req;  addr_s = imem_addr;
      ov_s = out_valid;  pc_s = out_pc;  instr_s = out_instr;  adel_s = out_adel;

      if (req_s) check("addr_align", {30'b0, addr_s[1:0]}, 32'h0);
      if (slave_busy) check("one_outstanding", {31'b0, req_s}, 32'h0);
      if (ov_s) check("hold_no_req", {31'b0, req_s}, 32'h0);
      if (prev_wb) begin
         check("wb_squash", {31'b0, ov_s}, 32'h0);
      end else if (prev_hold) begin
         check("stall_valid", {31'b0, ov_s}, 32'h1);
         check("stall_pc", pc_s, prev_pc);
         check("stall_instr", instr_s, prev_instr);
         check("stall_adel", {31'b0, adel_s}, {31'b0, prev_adel});
      end

      dok = slave_busy && (slave_cnt == 0) && d_en;
      imem_addr_ok = a_ok;
      imem_data_ok = dok;
      imem_rdata   = dok ? mem_word(slave_addr) : $urandom;
      out_ready    = rdy;
      wb_jmp_en    = wb;  wb_jmp_pc = wpc;
      br_jmp_en    = br;  br_jmp_pc = bpc;

      if (dok) slave_busy = 0;
      else if (slave_busy && slave_cnt > 0) slave_cnt--;

      if (req_s && a_ok) begin
         check("fetch_addr", addr_s, exp_pc);
         slave_busy = 1;
         slave_addr = addr_s;
         slave_cnt  = lat;
         exp_pc     = addr_s + 32'd4;
         if (!wb) exp_q.push_back('{pc: addr_s, instr: mem_word(addr_s), adel: 1'b0});
      end

      if (ov_s && rdy && !wb) begin
         deliveries++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else if (exp_pc[1:0] != 2'b00) begin
            e = '{pc: exp_pc, instr: 32'h0, adel: 1'b1};
         end else begin
            check("unexpected_out", {31'b0, ov_s}, 32'h0);
            e = '{pc: pc_s, instr: instr_s, adel: adel_s};
         end
         check("out_pc", pc_s, e.pc);
         check("out_instr", instr_s, e.instr);
         check("out_adel", {31'b0, adel_s}, {31'b0, e.adel});
         last_pc = pc_s;  last_instr = instr_s;  last_adel = adel_s;
      end

      if (wb) begin
         exp_pc = wpc;
         exp_q.delete();
      end else if (br) begin
         exp_pc = bpc;
      end

      prev_wb   = wb;
      prev_hold = ov_s && !rdy && !wb;
      prev_pc   = pc_s;  prev_instr = instr_s;  prev_adel = adel_s;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic run_until_req();
      for (int i = 0; i < 20 && !imem_req; i++) idle();
      check("req_timeout", {31'b0, imem_req}, 32'h1);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      imem_addr_ok = 0;  imem_data_ok = 0;  imem_rdata = 0;  out_ready = 0;
      wb_jmp_en = 0;  wb_jmp_pc = 0;  br_jmp_en = 0;  br_jmp_pc = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_adel", {31'b0, out_adel}, 32'h0);
      resetn = 1'b1;
      model_reset();
      check("rst_req", {31'b0, imem_req}, 32'h1);
      check("rst_addr", imem_addr, RST_PC);
   endtask

   initial begin
      deliveries = 0;
      lat = 0;
      last_pc = 0;  last_instr = 0;  last_adel = 0;
      model_reset();
      do_reset();

      // straight-line fetch at minimum latency: one instruction every 3 cycles
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check("seq_count", deliveries, 2);
      check("seq_last_pc", last_pc, 32'hbfc00004);

      // decode stall for 5 cycles in HOLD
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle();
      check("stall_deliver_pc", last_pc, 32'hbfc00008);
      run_until_req();
      check("after_stall_addr", imem_addr, 32'hbfc0000c);

      // writeback redirect while waiting: stale response dropped
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'hbfc00380, 1'b0, 32'h0, 1'b0);
      idle();
      run_until_req();
      check("wb_target_addr", imem_addr, 32'hbfc00380);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle();
      idle();
      check("wb_deliver_pc", last_pc, 32'hbfc00380);

      // branch in the same cycle as an accepted request: delay slot kept
      run_until_req();
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b1);
      idle();
      idle();
      check("br_slot_pc", last_pc, 32'hbfc00384);
      run_until_req();
      check("br_target_addr", imem_addr, 32'h80001000);

      // writeback and branch together: writeback wins
      step(1'b0, 1'b1, 1'b1, 32'hbfc00100, 1'b1, 32'h80002000, 1'b1);
      run_until_req();
      check("wb_over_br_addr", imem_addr, 32'hbfc00100);

      // misaligned branch target becomes an AdEL entry
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000002, 1'b1);
      idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle();
      check("adel_pc", last_pc, 32'h80000002);
      check("adel_flag", {31'b0, last_adel}, 32'h1);
      check("adel_instr", last_instr, 32'h0);
      check("adel_no_req", {31'b0, imem_req}, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b1);

      // randomized traffic, with one reset in the middle
      for (int c = 0; c < 3000; c++) begin
         bit          a_ok, rdy, wb, br, d_en;
         logic [31:0] wpc, bpc;
         if (c == 1500) do_reset();
         lat  = $urandom_range(0, 3);
         a_ok = ($urandom_range(0, 1) == 1);
         rdy  = ($urandom_range(0, 4) < 3);
         d_en = ($urandom_range(0, 3) != 0);
         wb   = ($urandom_range(0, 24) == 0);
         br   = ($urandom_range(0, 9) == 0);
         wpc  = 32'hbfc00000 | {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         bpc  = 32'h80000000 | ($urandom & 32'h0000fffc);
         step(a_ok, rdy, wb, wpc, br, bpc, d_en);
      end
      check("random_progress", {31'b0, (deliveries > 200)}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
